// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path and the keyboard decoder.
package ps2_pkg;

    // Receiver frame position.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Set-2 scan codes used by the downstream keyboard decoder.
    localparam logic [7:0] BREAK       = 8'hF0;
    localparam logic [7:0] EXTEND      = 8'hE0;
    localparam logic [7:0] ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] ARROW_RIGHT = 8'h74;

    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_B = 8'h32;
    localparam logic [7:0] KEY_C = 8'h21;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_F = 8'h2B;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_H = 8'h33;

    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_5 = 8'h2E;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h3D;
    localparam logic [7:0] KEY_8 = 8'h3E;

    // A frame is good when data plus parity has an odd number of ones
    // and the stop bit is high.
    function automatic logic ps2_frame_good(input logic [7:0] data,
                                            input logic       parity,
                                            input logic       stopBit);
        return ((^data) ^ parity) & stopBit;
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Bundles the raw PS/2 pins and the decoded byte outputs.
interface ps2_frame_receiver_if;

    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       frame_error;

    // Master drives the pins (device side) and observes the decoded bytes.
    modport master (
        output ps2_clk,
        output ps2_dat,
        input  ps2_key_data,
        input  ps2_key_pressed,
        input  ps2_out,
        input  frame_error
    );

    // Slave is the receiver itself.
    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output ps2_key_data,
        output ps2_key_pressed,
        output ps2_out,
        output frame_error
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronises the asynchronous PS/2 clock and data pins and produces a
// registered one-cycle pulse on each falling edge of the synced clock.
// The data output is registered alongside the pulse so both line up.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_ps2Clk,
    input  logic i_ps2Dat,
    output logic o_dat,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_datSync;
    logic                   r_clkPrev;
    logic                   r_fall;
    logic                   r_dat;

    // Shift the pins through the synchroniser chains; idle bus level is 1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clkSync <= '1;
            r_datSync <= '1;
            r_clkPrev <= 1'b1;
            r_fall    <= 1'b0;
            r_dat     <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], i_ps2Clk};
            r_datSync <= {r_datSync[SYNC_STAGES-2:0], i_ps2Dat};
            r_clkPrev <= r_clkSync[SYNC_STAGES-1];
            r_fall    <= r_clkPrev & ~r_clkSync[SYNC_STAGES-1];
            r_dat     <= r_datSync[SYNC_STAGES-1];
        end
    end

    assign o_dat  = r_dat;
    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_frame_receiver.sv
// Deserialises PS/2 device frames into scan-code bytes, keeping the
// previously accepted byte so break sequences can be recognised.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    ps2_frame_receiver_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            w_dat;
    logic            w_fall;

    ps2_state_t      r_state,    w_stateNext;
    logic [2:0]      r_bitCnt,   w_bitCntNext;
    logic [7:0]      r_shift,    w_shiftNext;
    logic            r_parity,   w_parityNext;
    logic [TO_W-1:0] r_toCnt,    w_toCntNext;
    logic [7:0]      r_keyData,  w_keyDataNext;
    logic [7:0]      r_prevKey,  w_prevKeyNext;
    logic            r_pressed,  w_pressedNext;
    logic            r_error,    w_errorNext;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_syncEdge (
        .clock   (clock),
        .reset   (reset),
        .i_ps2Clk(bus.ps2_clk),
        .i_ps2Dat(bus.ps2_dat),
        .o_dat   (w_dat),
        .o_fall  (w_fall)
    );

    // State and datapath registers; reset drops any partial frame silently.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_toCnt   <= '0;
            r_keyData <= '0;
            r_prevKey <= '0;
            r_pressed <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_bitCnt  <= w_bitCntNext;
            r_shift   <= w_shiftNext;
            r_parity  <= w_parityNext;
            r_toCnt   <= w_toCntNext;
            r_keyData <= w_keyDataNext;
            r_prevKey <= w_prevKeyNext;
            r_pressed <= w_pressedNext;
            r_error   <= w_errorNext;
        end
    end

    // Frame sequencing: a falling edge always wins over timeout expiry.
    always_comb begin
        w_stateNext   = r_state;
        w_bitCntNext  = r_bitCnt;
        w_shiftNext   = r_shift;
        w_parityNext  = r_parity;
        w_toCntNext   = r_toCnt;
        w_keyDataNext = r_keyData;
        w_prevKeyNext = r_prevKey;
        w_pressedNext = 1'b0;
        w_errorNext   = 1'b0;

        if (r_state == ST_IDLE) begin
            w_toCntNext = '0;
            if (w_fall && !w_dat) begin
                w_stateNext  = ST_DATA;
                w_bitCntNext = '0;
            end
        end else if (w_fall) begin
            w_toCntNext = '0;
            case (r_state)
                ST_DATA: begin
                    w_shiftNext  = {w_dat, r_shift[7:1]};
                    w_bitCntNext = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_parityNext = w_dat;
                    w_stateNext  = ST_STOP;
                end
                ST_STOP: begin
                    w_stateNext = ST_IDLE;
                    if (ps2_frame_good(r_shift, r_parity, w_dat)) begin
                        w_keyDataNext = r_shift;
                        w_prevKeyNext = r_keyData;
                        w_pressedNext = 1'b1;
                    end else begin
                        w_errorNext = 1'b1;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end else if (r_toCnt == TO_LAST) begin
            w_stateNext = ST_IDLE;
            w_toCntNext = '0;
            w_errorNext = 1'b1;
        end else begin
            w_toCntNext = r_toCnt + TO_W'(1);
        end
    end

    assign bus.ps2_key_data    = r_keyData;
    assign bus.ps2_out         = r_prevKey;
    assign bus.ps2_key_pressed = r_pressed;
    assign bus.frame_error     = r_error;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for the PS/2 frame receiver: stimulus pushes expected
// strobes into a queue, a monitor pops and compares each strobe it sees.
module tb_ps2_frame_receiver;

    localparam int SYNC    = 2;
    localparam int TIMEOUT = 500;
    localparam int HALF    = 20;

    typedef struct packed {
        logic       isErr;
        logic [7:0] key;
        logic [7:0] prev;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int vectorsApplied = 0;
    int miscompares    = 0;

    exp_t expQ[$];

    ps2_frame_receiver_if bus();

    ps2_frame_receiver #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W          (10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // 100 MHz system clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic isErr, input logic [7:0] key, input logic [7:0] prev);
        exp_t e;
        e.isErr = isErr;
        e.key   = key;
        e.prev  = prev;
        expQ.push_back(e);
    endtask

    // Drive nBits of a frame (start, 8 data LSB first, parity, stop).
    task automatic applyStimulus(input logic [7:0] data, input logic flipParity,
                                 input logic stopBit, input int nBits, input logic checkLat);
        logic [10:0] bits;
        bits = {stopBit, (~^data) ^ flipParity, data, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            bus.ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            bus.ps2_clk = 1'b0;
            if (checkLat && i == 10) begin
                repeat (SYNC + 1) @(negedge clock);
                checkOutput("latency early", {7'b0, bus.ps2_key_pressed}, 8'd0);
                @(negedge clock);
                checkOutput("latency strobe", {7'b0, bus.ps2_key_pressed}, 8'd1);
                repeat (HALF - SYNC - 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        bus.ps2_dat = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (bus.ps2_key_pressed === 1'b1 || bus.frame_error === 1'b1) begin
            checkOutput("exclusive strobes", {7'b0, bus.ps2_key_pressed & bus.frame_error}, 8'd0);
            if (expQ.size() == 0) begin
                vectorsApplied++;
                miscompares++;
                $display("[TB] FAIL unexpected strobe: got pressed=%b error=%b, expected none",
                         bus.ps2_key_pressed, bus.frame_error);
            end else begin
                e = expQ.pop_front();
                checkOutput("strobe kind", {7'b0, bus.frame_error}, {7'b0, e.isErr});
                checkOutput("key data", bus.ps2_key_data, e.key);
                checkOutput("prev key", bus.ps2_out, e.prev);
            end
        end
    end

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        reset       = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset key", bus.ps2_key_data, 8'h00);
        checkOutput("reset prev", bus.ps2_out, 8'h00);
        checkOutput("reset pressed", {7'b0, bus.ps2_key_pressed}, 8'd0);
        checkOutput("reset error", {7'b0, bus.frame_error}, 8'd0);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // Valid 0x1C with latency check.
        pushExp(1'b0, 8'h1C, 8'h00);
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b1);

        // Break sequence F0 then 1C.
        pushExp(1'b0, 8'hF0, 8'h1C);
        applyStimulus(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        pushExp(1'b0, 8'h1C, 8'hF0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0);

        // Parity error on 0x16, then a clean 0x16.
        pushExp(1'b1, 8'h1C, 8'hF0);
        applyStimulus(8'h16, 1'b1, 1'b1, 11, 1'b0);
        pushExp(1'b0, 8'h16, 8'h1C);
        applyStimulus(8'h16, 1'b0, 1'b1, 11, 1'b0);

        // Stop-bit error on 0x74.
        pushExp(1'b1, 8'h16, 8'h1C);
        applyStimulus(8'h74, 1'b0, 1'b0, 11, 1'b0);

        // Truncated frame times out, then 0x6B is accepted.
        pushExp(1'b1, 8'h16, 8'h1C);
        applyStimulus(8'h55, 1'b0, 1'b1, 4, 1'b0);
        repeat (TIMEOUT + 50) @(negedge clock);
        pushExp(1'b0, 8'h6B, 8'h16);
        applyStimulus(8'h6B, 1'b0, 1'b1, 11, 1'b0);

        // Reset in the middle of a frame; leftover edges must be ignored.
        applyStimulus(8'hAA, 1'b0, 1'b1, 3, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("mid reset key", bus.ps2_key_data, 8'h00);
        checkOutput("mid reset prev", bus.ps2_out, 8'h00);
        checkOutput("mid reset pressed", {7'b0, bus.ps2_key_pressed}, 8'd0);
        reset = 1'b1;
        bus.ps2_dat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (HALF) @(negedge clock);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        pushExp(1'b0, 8'h1E, 8'h00);
        applyStimulus(8'h1E, 1'b0, 1'b1, 11, 1'b0);

        repeat (50) @(negedge clock);
        checkOutput("queue drained", 8'(expQ.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Upstream stage of the keyboard command decoder.
- Deserialises raw PS/2 device clock/data lines into validated scan-code bytes.
- Presents each byte as ps2_key_data with a one-cycle ps2_key_pressed strobe.
- Holds the previously accepted byte on ps2_out, so the decoder can recognise break sequences (F0 followed by a code).

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers on ps2_clk and ps2_dat (minimum 2).
- TIMEOUT_CYCLES, 50000: system-clock cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).
- TO_W, 16: counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clock.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- ps2_key_data  out  8  last accepted scan-code byte.
- ps2_key_pressed  out  1  one-cycle strobe: ps2_key_data updated this cycle.
- ps2_out  out  8  byte accepted immediately before the current ps2_key_data.
- frame_error  out  1  one-cycle strobe: frame discarded (parity, stop or timeout).

Behaviour:
- Reset (reset == 0 at posedge):
  - ps2_key_data = 8'h00, ps2_out = 8'h00, ps2_key_pressed = 0, frame_error = 0.
  - FSM = IDLE; bit counter, shift register and timeout counter cleared.
  - Synchroniser flops preset to 1 (idle bus level).
  - Reset overrides everything, including mid-frame; the partial frame is lost with no error strobe.
- Synchronisation:
  - ps2_clk and ps2_dat each pass through SYNC_STAGES flops.
  - fall = (previous synced clk == 1) && (current synced clk == 0).
  - Data is sampled only in the cycle where fall == 1, using synced ps2_dat.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with dat == 0 (start bit) -> DATA, bit count = 0. On fall with dat == 1 -> stay in IDLE (spurious edge), no error.
  - DATA: on each fall, shift dat in LSB first (bit 0 arrives first); after the 8th bit -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall, evaluate the frame, then -> IDLE.
- Frame evaluation (STOP):
  - Frame is good when (XOR of 8 data bits XOR parity bit) == 1 (odd parity) and stop bit == 1.
  - Good frame, next cycle: ps2_out <= old ps2_key_data; ps2_key_data <= byte; ps2_key_pressed = 1 for exactly that one cycle.
  - Bad frame: ps2_key_data and ps2_out unchanged; frame_error = 1 for one cycle.
- Latency:
  - Strobe is asserted the cycle after fall is detected for the stop bit.
  - That is SYNC_STAGES + 2 clock cycles after the pin edge.
- Timeout:
  - Counter clears on every fall and is held at 0 in IDLE.
  - In DATA/PARITY/STOP, when the count reaches TIMEOUT_CYCLES-1 -> IDLE with a frame_error pulse; outputs are not updated.
- Simultaneous events: a fall in the same cycle as timeout expiry is processed normally and the timeout is ignored.
- ps2_key_pressed and frame_error are never high in the same cycle.
- No host-to-device transmission; ps2_clk and ps2_dat are inputs only.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (2-bit).
  - Scan-code constants: BREAK = 8'hF0, EXTEND = 8'hE0, ARROW_LEFT = 8'h6B, ARROW_RIGHT = 8'h74, letters A–H and digits 1–8, reused by the keyboard decoder.
- One natural sub-module: ps2_sync_edge (parameterised synchroniser plus falling-edge detector). It outputs synced data and the fall pulse.

Test Plan:
- Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> ps2_key_data = 8'h1C with a single-cycle ps2_key_pressed, SYNC_STAGES+2 cycles after the stop edge; ps2_out = 8'h00.
- Frames F0 then 1C -> after the second strobe, ps2_key_data = 8'h1C and ps2_out = 8'hF0; exactly two strobes total.
- Frame 0x16 with parity flipped to 1 -> no ps2_key_pressed, one frame_error pulse, ps2_key_data keeps its prior value; next valid 0x16 is accepted.
- Frame 0x74 with stop bit 0 -> one frame_error, outputs unchanged.
- 4 bits of a frame, then idle for TIMEOUT_CYCLES -> frame_error at expiry, FSM back in IDLE; a following full 0x6B frame is accepted correctly.
- reset driven 0 for one cycle mid-DATA -> all outputs 0, no strobes; remaining edges of that frame (data-bit edges with dat=1) are ignored; next full frame 0x1E is accepted.
